// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded RV32I fields into words and streams them into instruction memory
// Optional immediate range checking: define ENC_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [2:0]        cmd_funct3,
  input  logic [6:0]        cmd_funct7,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [20:0]       cmd_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              halted,
  output logic              full,
  output logic              err,
  output logic              err_sticky
);

  typedef enum logic [1:0] {LOAD, HALTED, FULL} stateT;

  localparam logic [2:0] kindLw   = 3'd0;
  localparam logic [2:0] kindSw   = 3'd1;
  localparam logic [2:0] kindR    = 3'd2;
  localparam logic [2:0] kindBr   = 3'd3;
  localparam logic [2:0] kindIAlu = 3'd4;
  localparam logic [2:0] kindJal  = 3'd5;
  localparam logic [2:0] kindJalr = 3'd6;

  localparam logic [ADDR_W-1:0] addrOne  = 1;
  localparam logic [ADDR_W-1:0] addrLast = '1;
  localparam logic [ADDR_W:0]   cntOne   = 1;
  localparam logic [ADDR_W:0]   cntMax   = 1 << ADDR_W;

  stateT             state, stateNext;
  logic [ADDR_W-1:0] addr;
  logic              fullReg;
  logic [31:0]       encWord;
  logic              isShift, isLast, accept, rangeOk, doWrite, doErr;

  assign isShift   = (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101);
  assign isLast    = (addr == addrLast);
  assign cmd_ready = (state == LOAD) && !clear;
  assign accept    = cmd_valid && cmd_ready;
  assign doWrite   = accept && rangeOk;
  assign doErr     = accept && !rangeOk;
  assign halted    = (state == HALTED);
  assign full      = fullReg;

  always_comb begin
    encWord = 32'h0000_0044;
    case (cmd_kind)
      kindLw:   encWord = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
      kindSw:   encWord = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
      kindR:    encWord = {cmd_funct7, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, 7'b0110011};
      kindBr:   encWord = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                           cmd_imm[4:1], cmd_imm[11], 7'b1100011};
      kindIAlu: encWord = isShift
                  ? {cmd_funct7, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011}
                  : {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, 7'b0010011};
      kindJal:  encWord = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12],
                           cmd_rd, 7'b1101111};
      kindJalr: encWord = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b1100111};
      default:  encWord = 32'h0000_0044;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic fitsI, fitsShamt, fitsB, fitsJ;
  logic errReg, errStickyReg;

  assign fitsI     = (cmd_imm[20:11] == {10{cmd_imm[11]}});
  assign fitsShamt = (cmd_imm[20:5] == 16'd0);
  assign fitsB     = (cmd_imm[20:12] == {9{cmd_imm[12]}}) && !cmd_imm[0];
  assign fitsJ     = !cmd_imm[0];

  always_comb begin
    rangeOk = 1'b1;
    case (cmd_kind)
      kindLw, kindSw, kindJalr: rangeOk = fitsI;
      kindIAlu:                 rangeOk = isShift ? fitsShamt : fitsI;
      kindBr:                   rangeOk = fitsB;
      kindJal:                  rangeOk = fitsJ;
      default:                  rangeOk = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      errReg       <= 1'b0;
      errStickyReg <= 1'b0;
    end else begin
      errReg       <= doErr;
      errStickyReg <= clear ? 1'b0 : (errStickyReg | doErr);
    end
  end

  assign err        = errReg;
  assign err_sticky = errStickyReg;
`else
  assign rangeOk    = 1'b1;
  assign err        = 1'b0;
  assign err_sticky = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    if (clear) begin
      stateNext = LOAD;
    end else if (doWrite) begin
      if (cmd_kind == 3'd7) stateNext = HALTED;
      else if (isLast)      stateNext = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      addr       <= '0;
      word_count <= '0;
      fullReg    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= stateNext;
      imem_we <= doWrite;
      if (doWrite) begin
        imem_addr  <= addr;
        imem_wdata <= encWord;
      end
      if (clear) begin
        addr       <= '0;
        word_count <= '0;
        fullReg    <= 1'b0;
      end else if (doWrite) begin
        // Address parks on the last slot; the stop state keeps it from being reused.
        if (!isLast) addr <= addr + addrOne;
        if (word_count != cntMax) word_count <= word_count + cntOne;
        fullReg <= fullReg | isLast;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
// Range-check expectations follow ENC_RANGE_CHECK_EN.
module tb_instr_encoder_loader;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, clear, cmd_valid, cmd_ready;
  logic [2:0]    cmd_kind, cmd_funct3;
  logic [6:0]    cmd_funct7;
  logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2;
  logic [20:0]   cmd_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          halted, full, err, err_sticky;

  int            checkCount = 0;
  int            passCount  = 0;
  logic [63:0]   expQ[$];
  int            expAddr = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_funct3(cmd_funct3), .cmd_funct7(cmd_funct7),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .halted(halted), .full(full),
    .err(err), .err_sticky(err_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference I-layout encoder built from arithmetic field placement.
  function automatic logic [31:0] refEncI(input int f3, input int rd, input int rs1, input int imm);
    logic [31:0] w;
    w = 32'h13;
    w = w + 32'((imm & 'hFFF) * (1 << 20));
    w = w + 32'(rs1 * (1 << 15)) + 32'(f3 * (1 << 12)) + 32'(rd * (1 << 7));
    return w;
  endfunction

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = expQ.pop_front();
        check("imem_addr", 32'(imem_addr), e[63:32]);
        check("imem_wdata", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic sendCmd(input logic [2:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [20:0] imm, input bit expAccept, input bit expWrite,
                         input logic [31:0] expWord);
    @(negedge clk);
    cmd_kind = kind; cmd_funct3 = f3; cmd_funct7 = f7;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'(expAccept));
    if (expAccept && expWrite) begin
      expQ.push_back({32'(expAddr), expWord});
      expAddr++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    cmd_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    expAddr = 0;
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_sticky"}, 32'(err_sticky), 32'd0);
  endtask

  task automatic sendRandomIAlu();
    int f3s[6] = '{0, 2, 3, 4, 6, 7};
    int f3, rd, rs1, imm;
    f3  = f3s[$urandom_range(0, 5)];
    rd  = $urandom_range(0, 31);
    rs1 = $urandom_range(0, 31);
    imm = int'($urandom_range(0, 4095)) - 2048;
    sendCmd(3'd4, 3'(f3), 7'd0, 5'(rd), 5'(rs1), 5'd0, 21'(imm), 1'b1, 1'b1,
            refEncI(f3, rd, rs1, imm));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; cmd_valid = 1'b0;
    cmd_kind = '0; cmd_funct3 = '0; cmd_funct7 = '0;
    cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkResetValues("rst");
    reset = 1'b0;

    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 1'b1, 32'h0050_0093);
    idle();
    check("count_after_first", 32'(word_count), 32'd1);

    pulseClear();
    sendCmd(3'd1, 3'd0, 7'd0, 5'd0, 5'd3, 5'd2, 21'd8, 1'b1, 1'b1, 32'h0021_A423);
    sendCmd(3'd3, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'h1F_FFFC, 1'b1, 1'b1, 32'hFE00_0EE3);
    sendCmd(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1, 1'b1, 32'h0080_00EF);
    sendCmd(3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b1, 1'b1, 32'h0000_0044);
    idle();
    check("halted_set", 32'(halted), 32'd1);
    check("halted_ready", 32'(cmd_ready), 32'd0);
    check("halted_full", 32'(full), 32'd0);
    check("halted_count", 32'(word_count), 32'd4);
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0, 1'b1, 32'h0);
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0, 1'b1, 32'h0);
    idle();
    pulseClear();
    check("clear_halted", 32'(halted), 32'd0);
    check("clear_count", 32'(word_count), 32'd0);
    check("clear_ready", 32'(cmd_ready), 32'd1);

    sendCmd(3'd0, 3'd0, 7'd0, 5'd5, 5'd2, 5'd0, 21'h1F_FFFC, 1'b1, 1'b1, 32'hFFC1_2283);
    sendCmd(3'd2, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h4020_81B3);
    sendCmd(3'd6, 3'd0, 7'd0, 5'd0, 5'd1, 5'd0, 21'd0, 1'b1, 1'b1, 32'h0000_8067);
    sendCmd(3'd4, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 21'd3, 1'b1, 1'b1, 32'h4033_5293);
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd7, 1'b1, 1'b1, 32'h0070_0093);

    // clear and cmd_valid together: the prior write still lands, the new command is refused
    @(negedge clk);
    clear = 1'b1;
    cmd_valid = 1'b1;
    #1;
    check("clear_collision_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    cmd_valid = 1'b0;
    expAddr = 0;
    #1;
    check("collision_count", 32'(word_count), 32'd0);
    sendCmd(3'd4, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 21'd1, 1'b1, 1'b1, 32'h0010_0113);
    idle();

`ifdef ENC_RANGE_CHECK_EN
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1, 1'b0, 32'h0);
    idle();
    check("err_imm", 32'(err), 32'd1);
    check("err_sticky_imm", 32'(err_sticky), 32'd1);
    check("err_no_we", 32'(imem_we), 32'd0);
    sendCmd(3'd3, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd3, 1'b1, 1'b0, 32'h0);
    idle();
    check("err_branch", 32'(err), 32'd1);
    idle();
    check("err_pulse_end", 32'(err), 32'd0);
    check("err_sticky_hold", 32'(err_sticky), 32'd1);
    check("err_count", 32'(word_count), 32'd1);
`else
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1, 1'b1, 32'h8000_0093);
    sendCmd(3'd3, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd3, 1'b1, 1'b1, 32'h0000_0163);
    idle();
    idle();
    check("noerr_err", 32'(err), 32'd0);
    check("noerr_sticky", 32'(err_sticky), 32'd0);
    check("noerr_count", 32'(word_count), 32'd3);
`endif

    pulseClear();
    check("clear_err_sticky", 32'(err_sticky), 32'd0);
    for (int i = 0; i < (1 << AW); i++) sendRandomIAlu();
    idle();
    check("full_set", 32'(full), 32'd1);
    check("full_halted", 32'(halted), 32'd0);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(word_count), 32'(1 << AW));
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0, 1'b1, 32'h0);
    idle();

    pulseClear();
    check("clear_full", 32'(full), 32'd0);
    for (int i = 0; i < (1 << AW) - 1; i++) sendRandomIAlu();
    sendCmd(3'd7, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b1, 1'b1, 32'h0000_0044);
    idle();
    check("last_halt_halted", 32'(halted), 32'd1);
    check("last_halt_full", 32'(full), 32'd1);
    check("last_halt_count", 32'(word_count), 32'(1 << AW));

    pulseClear();
    sendCmd(3'd4, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 1'b1, 32'h0050_0093);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkResetValues("midrst");
    reset = 1'b0;
    cmd_valid = 1'b0;
    expAddr = 0;
    idle();
    idle();
    check("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RISC-V instruction encoder and instruction-memory loader for the single-cycle core's test and bring-up path. It is the inverse of the main control decoder:
- It accepts decoded instruction fields (class, registers, funct bits, immediate) over a valid/ready handshake.
- It packs them into 32-bit RV32I words covering exactly the opcode set the core decodes, including the custom HALT opcode.
- It writes each word to consecutive instruction-memory addresses.

Loading stops on HALT or when memory is full.

## Interface
- ADDR_W, 6, instruction-memory word-address width (capacity 2^ADDR_W words)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  restart loading at address 0 (synchronous, one-cycle pulse)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_kind  in  3  0 LW, 1 SW, 2 R-type, 3 branch, 4 I-ALU, 5 JAL, 6 JALR, 7 HALT
- cmd_funct3  in  3  funct3 (R, branch, I-ALU); ignored otherwise
- cmd_funct7  in  7  funct7 (R-type; I-ALU shifts, funct3=001/101); ignored otherwise
- cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register indices
- cmd_imm  in  21  signed immediate / byte offset
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  32  encoded instruction
- word_count  out  ADDR_W+1  words written since reset/clear
- halted  out  1  HALT written; loading stopped
- full  out  1  last address written; loading stopped
- err  out  1  one-cycle pulse: command rejected (range)
- err_sticky  out  1  any rejection since reset/clear

## Operation
- States: LOAD, HALTED, FULL.
  - LOAD: cmd_ready = !clear.
  - HALTED / FULL: cmd_ready = 0; only reset or clear exits, returning to LOAD.
- Handshake: accepted when cmd_valid && cmd_ready. cmd_* fields are sampled on the accept edge only.
- Encodings (op, funct3, layout):
  - LW: 0000011, funct3 010, I-layout.
  - SW: 0100011, funct3 010, imm[11:5] rs2 rs1 f3 imm[4:0] op.
  - R-type: 0110011, funct7 rs2 rs1 f3 rd op.
  - Branch: 1100011, imm[12|10:5] rs2 rs1 f3 imm[4:1|11] op.
  - I-ALU: 0010011, I-layout. When funct3 = 001 or 101, bits [31:25] = cmd_funct7 and [24:20] = imm[4:0].
  - JAL: 1101111, imm[20|10:1|11|19:12] rd op.
  - JALR: 1100111, funct3 000, I-layout.
  - HALT: 0x00000044 (opcode 1000100, all other bits 0).
- Unused fields are zero.
- Range rules (when checking is enabled):
  - I/S immediate in −2048..2047.
  - Shift amount 0..31.
  - Branch immediate in −4096..4094 and even.
  - JAL immediate in −1048576..1048574 and even.
- Rejected command:
  - err pulses and err_sticky sets.
  - No write occurs; address and count are unchanged; state stays LOAD.
- Accepted valid command:
  - The word is written at the current address; the address and word_count increment.
  - HALT → HALTED, after its word is written.
  - A write to address 2^ADDR_W−1 → FULL. A HALT written to the last address → HALTED, with full also set.
- Address counter never wraps. word_count saturates at 2^ADDR_W.

## Timing
- Latency 1: the accept edge registers the word; imem_we/imem_addr/imem_wdata are valid the following cycle for exactly one cycle.
- Back-to-back accepts are allowed every cycle; throughput 1 word/clk.
- Stop flags:
  - halted/full assert in the same cycle as the final imem_we.
  - cmd_ready drops in that same cycle (registered state), so no command is accepted after the final one.
- clear with cmd_valid in the same cycle: clear wins (cmd_ready = 0); next cycle is LOAD at address 0 with count, flags and err_sticky zeroed. A write registered on the previous edge still completes.
- Reset values:
  - State LOAD, address 0, word_count 0.
  - cmd_ready 1, imem_we 0, imem_addr 0, imem_wdata 0.
  - halted 0, full 0, err 0, err_sticky 0.
- Reset mid-operation drops any pending write (imem_we = 0 the cycle after reset).

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - Range rules enforced; err/err_sticky functional.
- ENC_RANGE_CHECK_EN undefined:
  - No checking; immediates are truncated to field width and branch/JAL bit 0 is dropped.
  - err and err_sticky are tied 0.
  - Every command writes.

## Test plan
- Reset, then I-ALU, rd=1, rs1=0, f3=000, imm=5 → next cycle imem_we=1, addr 0, wdata 0x00500093; word_count=1.
- SW rs2=2, rs1=3, imm=8, then branch f3=000, rs1=rs2=0, imm=−4, then JAL rd=1, imm=8, back-to-back → wdata 0x0021A423, 0xFE000EE3, 0x008000EF at addrs 0, 1, 2 on consecutive cycles.
- HALT at addr 3 → wdata 0x00000044, halted=1, cmd_ready=0; further cmd_valid yields no write; clear → addr 0, halted=0.
- With ENC_RANGE_CHECK_EN: I-ALU imm=2048, then branch imm=3 → two err pulses, err_sticky=1, no imem_we, addr unchanged. Without the macro: imm=2048 writes wdata with imm field 0x800.
- ADDR_W=2, four valid commands → full=1 with the fourth write at addr 3; cmd_ready=0; word_count=4.
- Reset asserted the cycle after an accept → no imem_we; all outputs at reset values.
